// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MdOp encodings, FSM states and iteration count for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} md_state_e;
  localparam int MD_ITERS = 32;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: Start/MdOp/A/B/HiWE/LoWE/WD requests in, Busy/Done/DivByZero/Hi/Lo results out
interface mult_div_unit_if import mdu_pkg::*; #(parameter int WIDTH = MD_ITERS) ();
  logic Start;
  md_op_e MdOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic HiWE;
  logic LoWE;
  logic [WIDTH-1:0] WD;
  logic Busy;
  logic Done;
  logic DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  modport master (output Start, MdOp, A, B, HiWE, LoWE, WD, input Busy, Done, DivByZero, Hi, Lo);
  modport slave (input Start, MdOp, A, B, HiWE, LoWE, WD, output Busy, Done, DivByZero, Hi, Lo);
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 shift-add multiply or restoring shift-subtract divide iteration
module mdu_step #(parameter int WIDTH = 32) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem = acc[2*WIDTH-1:WIDTH-1];
    diff = rem - {1'b0, operand};
    acc_next = is_div ? {diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                      : {acc[0] ? sum : {1'b0, acc[2*WIDTH-1:WIDTH]}, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply/divide with HI/LO registers and Start/Busy/Done handshake
module mult_div_unit import mdu_pkg::*; #(parameter int WIDTH = MD_ITERS) (
  input logic Clk,
  input logic Rst_n,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  md_state_e state_q, state_d;
  logic is_div_q, is_div_d, sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, full;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, dbz_q, dbz_d;
  logic accept, sgn, dz, idle, fix;
  logic [WIDTH-1:0] res_hi, res_lo;
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div(is_div_q),
    .acc(acc_q),
    .operand(is_div_q ? mag_b_q : mag_a_q),
    .acc_next(acc_step)
  );
  always_comb begin
    idle = state_q == S_IDLE;
    fix = state_q == S_FIX;
    accept = idle && bus.Start;
    sgn = bus.MdOp == MD_MULT || bus.MdOp == MD_DIV;
    dz = is_div_q && mag_b_q == '0;
    full = (sa_q ^ sb_q) ? -acc_q : acc_q;
    res_hi = dz ? (sa_q ? -mag_a_q : mag_a_q)
           : is_div_q ? (sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH])
           : full[2*WIDTH-1:WIDTH];
    res_lo = dz ? '1
           : is_div_q ? ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])
           : full[WIDTH-1:0];
    state_d = idle ? (bus.Start ? S_PREP : S_IDLE)
            : state_q == S_PREP ? (dz ? S_FIX : S_RUN)
            : state_q == S_RUN ? (cnt_q == CW'(WIDTH-1) ? S_FIX : S_RUN)
            : S_IDLE;
    is_div_d = accept ? (bus.MdOp == MD_DIV || bus.MdOp == MD_DIVU) : is_div_q;
    sa_d = accept ? sgn & bus.A[WIDTH-1] : sa_q;
    sb_d = accept ? sgn & bus.B[WIDTH-1] : sb_q;
    mag_a_d = accept ? ((sgn & bus.A[WIDTH-1]) ? -bus.A : bus.A) : mag_a_q;
    mag_b_d = accept ? ((sgn & bus.B[WIDTH-1]) ? -bus.B : bus.B) : mag_b_q;
    acc_d = state_q == S_PREP ? {{WIDTH{1'b0}}, is_div_q ? mag_a_q : mag_b_q}
          : state_q == S_RUN ? acc_step : acc_q;
    cnt_d = state_q == S_PREP ? '0 : state_q == S_RUN ? cnt_q + 1'b1 : cnt_q;
    hi_d = fix ? res_hi : (idle && bus.HiWE) ? bus.WD : hi_q;
    lo_d = fix ? res_lo : (idle && bus.LoWE) ? bus.WD : lo_q;
    done_d = fix;
    dbz_d = fix ? dz : accept ? 1'b0 : dbz_q;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      is_div_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_div_q <= is_div_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
    end
  end
  assign bus.Busy = state_q != S_IDLE;
  assign bus.Done = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Hi = hi_q;
  assign bus.Lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed self-checking bench against an arithmetic reference model
module tb_mult_div_unit;
  import mdu_pkg::*;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  mult_div_unit_if bus ();
  mult_div_unit dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  always #5 Clk = ~Clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic void model(input md_op_e op, input logic [31:0] a, b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] p;
    longint x, y, q, r;
    dz = 1'b0;
    p = '0;
    q = 0;
    r = 0;
    if (op == MD_MULT) p = longint'($signed(a)) * longint'($signed(b));
    if (op == MD_MULTU) p = {32'b0, a} * {32'b0, b};
    if (op == MD_DIV || op == MD_DIVU) begin
      x = (op == MD_DIV) ? longint'($signed(a)) : longint'({32'b0, a});
      y = (op == MD_DIV) ? longint'($signed(b)) : longint'({32'b0, b});
      if (y == 0) begin
        dz = 1'b1;
        q = -1;
        r = x;
      end else begin
        q = x / y;
        r = x % y;
      end
      p = {r[31:0], q[31:0]};
    end
    hi = p[63:32];
    lo = p[31:0];
  endfunction
  task automatic run_op(input md_op_e op, input logic [31:0] a, b, input int poke, input logic wr,
                        output int lat, output int busy_c, output logic dbz_s, output logic [31:0] hi_s);
    bus.Start = 1'b1;
    bus.MdOp = op;
    bus.A = a;
    bus.B = b;
    bus.HiWE = wr;
    bus.LoWE = wr;
    bus.WD = 32'hCAFE;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    bus.HiWE = 1'b0;
    bus.LoWE = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.MdOp = md_op_e'(2'($urandom_range(0, 3)));
    dbz_s = bus.DivByZero;
    hi_s = bus.Hi;
    lat = -1;
    busy_c = 0;
    for (int i = 1; i <= 60; i++) begin
      busy_c += int'(bus.Busy);
      if (i == poke) begin
        bus.Start = 1'b1;
        bus.HiWE = 1'b1;
        bus.LoWE = 1'b1;
        bus.WD = 32'd5;
      end
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      bus.HiWE = 1'b0;
      bus.LoWE = 1'b0;
      if (bus.Done) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge Clk);
    #1;
    tests++;
    if ({bus.Busy, bus.Done, bus.DivByZero} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=000", {bus.Busy, bus.Done, bus.DivByZero});
    end
    tests++;
    if ({bus.Hi, bus.Lo} !== 64'h0) begin
      fails++;
      $display("FAIL reset_hilo got=%h exp=0", {bus.Hi, bus.Lo});
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask
  task automatic test_directed();
    md_op_e ops [5] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIV, MD_DIVU};
    logic [31:0] as [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100};
    logic [31:0] bs [5] = '{32'd7, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
    logic [31:0] eh [5] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 32'd100};
    logic [31:0] el [5] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    int elat [5] = '{34, 34, 34, 34, 2};
    int lat, bc;
    logic ds;
    logic [31:0] hs;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      run_op(ops[k], as[k], bs[k], 0, 1'b0, lat, bc, ds, hs);
      tests++;
      if (lat !== elat[k] || bc !== elat[k]) begin
        fails++;
        $display("FAIL directed%0d_timing lat=%0d busy=%0d exp=%0d", k, lat, bc, elat[k]);
      end
      tests++;
      if ({bus.Hi, bus.Lo} !== {eh[k], el[k]} || bus.Busy !== 1'b0) begin
        fails++;
        $display("FAIL directed%0d_result got=%h_%h busy=%b exp=%h_%h busy=0", k, bus.Hi, bus.Lo, bus.Busy, eh[k], el[k]);
      end
      tests++;
      if (bus.DivByZero !== (k == 4)) begin
        fails++;
        $display("FAIL directed%0d_dbz got=%b exp=%b", k, bus.DivByZero, k == 4);
      end
    end
  endtask
  task automatic test_div_zero_clear();
    int lat, bc;
    logic ds;
    logic [31:0] hs;
    run_op(MD_MULTU, 32'd3, 32'd3, 0, 1'b0, lat, bc, ds, hs);
    tests++;
    if (ds !== 1'b0 || bus.DivByZero !== 1'b0 || bus.Lo !== 32'd9) begin
      fails++;
      $display("FAIL dbz_clear at_start=%b at_done=%b lo=%h exp=0,0,9", ds, bus.DivByZero, bus.Lo);
    end
  endtask
  task automatic test_random();
    md_op_e op;
    logic [31:0] a, b, eh, el;
    logic edz, ds;
    logic [31:0] hs;
    int lat, bc, bad;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      op = md_op_e'(2'($urandom_range(0, 3)));
      a = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = 32'hFFFFFFFF;
        3: b = 32'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      if (k % 3 == 0) @(negedge Clk);
      model(op, a, b, eh, el, edz);
      run_op(op, a, b, 0, 1'b0, lat, bc, ds, hs);
      tests++;
      if ({bus.Hi, bus.Lo, bus.DivByZero} !== {eh, el, edz} || lat !== (edz ? 2 : 34)) begin
        fails++;
        bad++;
        $display("FAIL random%0d op=%0d a=%h b=%h got=%h_%h dz=%b lat=%0d exp=%h_%h dz=%b lat=%0d",
                 k, op, a, b, bus.Hi, bus.Lo, bus.DivByZero, lat, eh, el, edz, edz ? 2 : 34);
      end
    end
  endtask
  task automatic test_busy_ignore();
    logic [31:0] a, b, eh, el;
    logic edz, ds;
    logic [31:0] hs;
    int lat, bc;
    a = $urandom;
    b = $urandom;
    model(MD_MULT, a, b, eh, el, edz);
    @(negedge Clk);
    run_op(MD_MULT, a, b, 6, 1'b0, lat, bc, ds, hs);
    tests++;
    if ({bus.Hi, bus.Lo} !== {eh, el} || lat !== 34) begin
      fails++;
      $display("FAIL busy_ignore got=%h_%h lat=%0d exp=%h_%h lat=34", bus.Hi, bus.Lo, lat, eh, el);
    end
    @(posedge Clk); #1;
    tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore_noqueue busy=%b done=%b exp=0,0", bus.Busy, bus.Done);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] eh, el;
    logic edz, ds;
    logic [31:0] hs;
    int lat, bc;
    @(negedge Clk);
    run_op(MD_DIVU, 32'd1000, 32'd7, 0, 1'b0, lat, bc, ds, hs);
    model(MD_MULT, 32'hFFFFFF00, 32'h12345, eh, el, edz);
    run_op(MD_MULT, 32'hFFFFFF00, 32'h12345, 0, 1'b0, lat, bc, ds, hs);
    tests++;
    if ({bus.Hi, bus.Lo} !== {eh, el} || lat !== 34 || bc !== 34) begin
      fails++;
      $display("FAIL back_to_back got=%h_%h lat=%0d busy=%0d exp=%h_%h lat=34", bus.Hi, bus.Lo, lat, bc, eh, el);
    end
  endtask
  task automatic test_mthi_mtlo();
    logic [31:0] eh, el;
    logic edz, ds;
    logic [31:0] hs;
    int lat, bc;
    logic [31:0] hi0;
    @(negedge Clk);
    hi0 = bus.Hi;
    bus.LoWE = 1'b1;
    bus.WD = 32'h1234;
    @(posedge Clk); #1;
    bus.LoWE = 1'b0;
    tests++;
    if (bus.Lo !== 32'h1234 || bus.Hi !== hi0) begin
      fails++;
      $display("FAIL mtlo lo=%h hi=%h exp lo=1234 hi=%h", bus.Lo, bus.Hi, hi0);
    end
    @(negedge Clk);
    bus.HiWE = 1'b1;
    bus.WD = 32'h5678;
    @(posedge Clk); #1;
    bus.HiWE = 1'b0;
    tests++;
    if (bus.Hi !== 32'h5678 || bus.Lo !== 32'h1234) begin
      fails++;
      $display("FAIL mthi hi=%h lo=%h exp hi=5678 lo=1234", bus.Hi, bus.Lo);
    end
    model(MD_DIV, 32'hFFFFFC00, 32'd9, eh, el, edz);
    @(negedge Clk);
    run_op(MD_DIV, 32'hFFFFFC00, 32'd9, 0, 1'b1, lat, bc, ds, hs);
    tests++;
    if (hs !== 32'hCAFE) begin
      fails++;
      $display("FAIL mthi_with_start hi=%h exp=0000cafe", hs);
    end
    tests++;
    if ({bus.Hi, bus.Lo} !== {eh, el}) begin
      fails++;
      $display("FAIL mthi_overwritten got=%h_%h exp=%h_%h", bus.Hi, bus.Lo, eh, el);
    end
  endtask
  task automatic test_async_reset();
    logic seen_done, busy_before, ds;
    logic [31:0] hs;
    int lat, bc;
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.MdOp = MD_DIV;
    bus.A = 32'd12345;
    bus.B = 32'd11;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2;
    busy_before = bus.Busy;
    Rst_n = 1'b0;
    #1;
    tests++;
    if (busy_before !== 1'b1 || {bus.Busy, bus.Done, bus.DivByZero, bus.Hi, bus.Lo} !== 67'h0) begin
      fails++;
      $display("FAIL async_reset busy_before=%b outs=%h exp busy_before=1 outs=0", busy_before,
               {bus.Busy, bus.Done, bus.DivByZero, bus.Hi, bus.Lo});
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      seen_done |= bus.Done | bus.Busy;
    end
    tests++;
    if (seen_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort activity=%b exp=0", seen_done);
    end
    @(negedge Clk);
    run_op(MD_MULT, 32'd6, 32'd7, 0, 1'b0, lat, bc, ds, hs);
    tests++;
    if ({bus.Hi, bus.Lo} !== 64'd42 || lat !== 34) begin
      fails++;
      $display("FAIL post_reset_mult got=%h_%h lat=%0d exp=0_2a lat=34", bus.Hi, bus.Lo, lat);
    end
  endtask
  initial begin
    bus.Start = 1'b0;
    bus.MdOp = MD_MULT;
    bus.A = '0;
    bus.B = '0;
    bus.HiWE = 1'b0;
    bus.LoWE = 1'b0;
    bus.WD = '0;
    test_reset();
    test_directed();
    test_div_zero_clear();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mthi_mtlo();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
